memory_burst_ctrl: RTL and testbench
====================================

# memory_burst_ctrl

Parametrised single-port memory access controller, the next generation of the coprocessor's start/done memory block. It owns an internal synchronous RAM and services single-word or burst reads and writes of up to 2^LEN_W consecutive words with address auto-increment. Handshake is level-start/level-done, with per-word write-data requests and read-data valid strobes. It sits between the coprocessor control FSM and its local data store.

## Interface
- DATA_W, 16: word width in bits
- ADDR_W, 8: address width; RAM depth is 2^ADDR_W words
- LEN_W, 4: burst length field width; a burst is len+1 words (1..2^LEN_W)
- WAIT_CYCLES, 4: settle cycles between accepting a request and the first transfer (0 allowed)
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request, level; held high by the master until done is seen
- wr  in  1  1 = write burst, 0 = read burst; sampled with start
- address  in  ADDR_W  first word address; sampled with start
- len  in  LEN_W  words minus one; sampled with start
- data_in  in  DATA_W  write word; must be valid whenever data_req is high
- data_req  out  1  write word consumed at this rising edge
- data_out  out  DATA_W  read word, registered; holds its last value
- data_out_valid  out  1  data_out carries a new word this cycle
- busy  out  1  request accepted and not yet in DONE
- done  out  1  burst complete; held while start stays high
- err  out  1  burst crossed the top of the address space; valid while done

## Operation
- States: IDLE, WAIT, XFER, DRAIN (read only), DONE.
- IDLE: if start=1, latch address, len, wr; clear the word counter; go to WAIT, or to XFER if WAIT_CYCLES=0.
- WAIT: count WAIT_CYCLES cycles, then go to XFER.
- XFER write: one word per cycle. data_req=1; data_in is written to RAM at the current address on the edge. Address increments by 1.
- XFER read: one RAM address is issued per cycle.
- After len+1 words, write goes to DONE and read goes to DRAIN. DRAIN lasts one cycle and captures the last RAM word.
- DONE: done=1 while start=1. When start=0, go to IDLE. A new request needs start low for at least one cycle.
- Address arithmetic is modulo 2^ADDR_W. If a burst passes address 2^ADDR_W-1, it wraps to 0 and continues, and the sticky err is set. err clears when the next request is accepted.
- Abort: start=0 in WAIT, XFER or DRAIN goes to IDLE on the next edge. done is not asserted and data_out_valid drops. Words already written stay in RAM.
- Reset, at any time and asynchronously: state goes to IDLE. data_out=0, data_out_valid=0, data_req=0, busy=0, done=0, err=0. RAM contents are not cleared.

## Timing
- Let W = WAIT_CYCLES and L = len+1. Cycle 0 is the first cycle with start=1 in IDLE.
- WAIT occupies cycles 1..W. XFER occupies cycles W+1..W+L. busy=1 from cycle 1 until DONE.
- Write: data_req=1 in cycles W+1..W+L. done=1 from cycle W+L+1.
- Read: RAM read latency is 1 cycle. data_out_valid=1 in cycles W+2..W+L+1. DRAIN is cycle W+L+1. done=1 from cycle W+L+2.
- done, busy, data_req and data_out_valid are all registered outputs.
- Throughput is one word per cycle, with no bubbles inside a burst.

## Structure
- Shared package (mem_pkg): state encoding enum and default parameter constants.
- Sub-module `ram_sp`: single-port synchronous RAM with parameters DATA_W and ADDR_W. It has write enable, is read-first, and has a 1-cycle registered read.
- Counters: the WAIT counter is sized for WAIT_CYCLES. The word counter is LEN_W+1 bits.

## Test plan
All scenarios use the defaults (16/8/4/4).
- Single write then single read: write 0x1234 to 0x10 with len=0 → data_req in cycle 5 and done in cycle 6. Read 0x10 → data_out=0x1234 with valid in cycle 6, done in cycle 7.
- Burst: write 0xA0..0xA3 to 0x20 with len=3 → data_req in cycles 5..8. Read-back burst → valid in cycles 6..9 with words in order. err=0 throughout.
- Wrap: write to 0xFE with len=3 → RAM locations FE, FF, 00, 01 written, and done with err=1. The next request clears err.
- Abort: start drops after the 2nd data_req of a 4-word write → IDLE next cycle and done never asserted. Only 2 words are changed.
- Asynchronous reset mid-read, between clock edges → all outputs 0 immediately. The next request behaves normally.
- start held after done → done stays high and no new burst starts. Drop start for 1 cycle, reassert → a new burst begins with correct cycle counts.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default parameters for the burst memory controller.
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_XFER  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_ADDR_W      = 8;
    localparam int unsigned DEF_LEN_W       = 4;
    localparam int unsigned DEF_WAIT_CYCLES = 4;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM: read-first, 1-cycle registered read.
// The read register holds its value when re is low; only it is reset.
module ram_sp #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_burst_ctrl.sv
// Start/done burst controller in front of an internal single-port RAM:
// single or burst reads/writes with address auto-increment and wrap detection.
module memory_burst_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr,
    input  logic [ADDR_W-1:0] address,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_req,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned WAIT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned WAIT_LAST = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam int unsigned CNT_W     = LEN_W + 1;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                wr_q, wr_d;
    logic                err_d;
    logic                busy_d, done_d, data_req_d, valid_d;
    logic                last_c;
    logic                ram_we_c, ram_re_c;

    assign last_c = (cnt_q == {1'b0, len_q});

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wait_q         <= '0;
            cnt_q          <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            wr_q           <= 1'b0;
            err            <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            data_req       <= 1'b0;
            data_out_valid <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            wr_q           <= wr_d;
            err            <= err_d;
            busy           <= busy_d;
            done           <= done_d;
            data_req       <= data_req_d;
            data_out_valid <= valid_d;
        end
    end

    // Next-state, datapath updates and next values of the registered outputs
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        len_d    = len_q;
        wr_d     = wr_q;
        err_d    = err;
        ram_we_c = 1'b0;
        ram_re_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = address;
                    len_d   = len;
                    wr_d    = wr;
                    cnt_d   = '0;
                    wait_d  = '0;
                    err_d   = 1'b0;
                    state_d = (WAIT_CYCLES == 0) ? ST_XFER : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (wait_q == WAIT_W'(WAIT_LAST)) begin
                    state_d = ST_XFER;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_XFER: begin
                // A word already promised by data_req is written even if start drops
                ram_we_c = wr_q;
                ram_re_c = !wr_q;
                addr_d   = addr_q + ADDR_W'(1);
                cnt_d    = cnt_q + CNT_W'(1);
                if (addr_q == '1 && !last_c) begin
                    err_d = 1'b1;
                end
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (last_c) begin
                    state_d = wr_q ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = start ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d == ST_WAIT) || (state_d == ST_XFER) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
        data_req_d = (state_d == ST_XFER) && wr_d;
        // RAM word issued this cycle appears on data_out next cycle
        valid_d    = (state_q == ST_XFER) && !wr_q && start;
    end

    ram_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_c),
        .re    (ram_re_c),
        .addr  (addr_q),
        .wdata (data_in),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_memory_burst_ctrl.sv
// Directed self-checking bench for memory_burst_ctrl with default parameters.
module tb_memory_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  address = '0;
    logic [3:0]  len = '0;
    logic [15:0] data_in = '0;
    logic        data_req;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] wbuf [16];
    logic [15:0] rbuf [16];
    int first_req, n_req, first_vld, n_vld, done_cyc;
    logic err_done;

    always #5 clk = ~clk;

    memory_burst_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .wr             (wr),
        .address        (address),
        .len            (len),
        .data_in        (data_in),
        .data_req       (data_req),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one burst; cycle 0 is the IDLE cycle in which start rises.
    // Outputs are sampled on the falling edge. After done, start is held for
    // `hold` extra cycles while checking that nothing new starts.
    task automatic run(input logic w, input logic [7:0] a, input logic [3:0] l, input int hold);
        first_req = -1; n_req = 0; first_vld = -1; n_vld = 0; done_cyc = -1; err_done = 1'b0;
        @(negedge clk);
        wr = w; address = a; len = l; data_in = wbuf[0]; start = 1'b1;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (data_req) begin
                if (first_req < 0) first_req = c;
                data_in = wbuf[n_req];
                n_req++;
            end
            if (data_out_valid) begin
                if (first_vld < 0) first_vld = c;
                rbuf[n_vld] = data_out;
                n_vld++;
            end
            if (done) begin
                done_cyc = c;
                err_done = err;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("held_done", 32'(done), 32'd1);
            check("held_idle", 32'({busy, data_req, data_out_valid}), 32'd0);
        end
        start = 1'b0;
    endtask

    initial begin
        #1;
        check("rst_outputs", 32'({data_req, data_out_valid, busy, done, err}), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single write then single read
        wbuf[0] = 16'h1234;
        run(1'b1, 8'h10, 4'd0, 0);
        check("w1_req_cyc", 32'(first_req), 32'd5);
        check("w1_req_n", 32'(n_req), 32'd1);
        check("w1_done_cyc", 32'(done_cyc), 32'd6);
        check("w1_err", 32'(err_done), 32'd0);
        run(1'b0, 8'h10, 4'd0, 0);
        check("r1_vld_cyc", 32'(first_vld), 32'd6);
        check("r1_vld_n", 32'(n_vld), 32'd1);
        check("r1_data", 32'(rbuf[0]), 32'h1234);
        check("r1_done_cyc", 32'(done_cyc), 32'd7);

        // Four-word burst and read-back
        for (int i = 0; i < 4; i++) wbuf[i] = 16'h00A0 + 16'(i);
        run(1'b1, 8'h20, 4'd3, 0);
        check("w4_req_cyc", 32'(first_req), 32'd5);
        check("w4_req_n", 32'(n_req), 32'd4);
        check("w4_done_cyc", 32'(done_cyc), 32'd9);
        check("w4_err", 32'(err_done), 32'd0);
        run(1'b0, 8'h20, 4'd3, 0);
        check("r4_vld_cyc", 32'(first_vld), 32'd6);
        check("r4_vld_n", 32'(n_vld), 32'd4);
        for (int i = 0; i < 4; i++) check("r4_data", 32'(rbuf[i]), 32'h00A0 + 32'(i));
        check("r4_done_cyc", 32'(done_cyc), 32'd10);
        check("r4_err", 32'(err_done), 32'd0);

        // Wrap past the top of the address space
        for (int i = 0; i < 4; i++) wbuf[i] = 16'h00B0 + 16'(i);
        run(1'b1, 8'hFE, 4'd3, 0);
        check("wrap_w_done_cyc", 32'(done_cyc), 32'd9);
        check("wrap_w_err", 32'(err_done), 32'd1);
        run(1'b0, 8'hFE, 4'd3, 0);
        for (int i = 0; i < 4; i++) check("wrap_r_data", 32'(rbuf[i]), 32'h00B0 + 32'(i));
        check("wrap_r_err", 32'(err_done), 32'd1);
        run(1'b0, 8'h00, 4'd1, 0);
        check("wrap_low_d0", 32'(rbuf[0]), 32'h00B2);
        check("wrap_low_d1", 32'(rbuf[1]), 32'h00B3);
        check("wrap_err_clr", 32'(err_done), 32'd0);

        // Abort a write after its second consumed word
        for (int i = 0; i < 4; i++) wbuf[i] = 16'h5550 + 16'(i);
        run(1'b1, 8'h40, 4'd3, 0);
        for (int i = 0; i < 4; i++) wbuf[i] = 16'h00C0 + 16'(i);
        n_req = 0;
        @(negedge clk);
        wr = 1'b1; address = 8'h40; len = 4'd3; data_in = wbuf[0]; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (data_req) begin
                data_in = wbuf[n_req];
                n_req++;
            end
        end
        start = 1'b0;
        check("abort_req_n", 32'(n_req), 32'd2);
        @(negedge clk);
        check("abort_idle", 32'({busy, data_req, done}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        run(1'b0, 8'h40, 4'd3, 0);
        check("abort_d0", 32'(rbuf[0]), 32'h00C0);
        check("abort_d1", 32'(rbuf[1]), 32'h00C1);
        check("abort_d2", 32'(rbuf[2]), 32'h5552);
        check("abort_d3", 32'(rbuf[3]), 32'h5553);

        // Asynchronous reset in the middle of a read burst
        @(negedge clk);
        wr = 1'b0; address = 8'h20; len = 4'd3; start = 1'b1;
        for (int c = 1; c <= 7; c++) @(negedge clk);
        check("mid_read_valid", 32'(data_out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", 32'({data_req, data_out_valid, busy, done, err}), 32'd0);
        check("async_rst_data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        run(1'b0, 8'h20, 4'd3, 0);
        check("post_rst_vld_cyc", 32'(first_vld), 32'd6);
        check("post_rst_d3", 32'(rbuf[3]), 32'h00A3);
        check("post_rst_done_cyc", 32'(done_cyc), 32'd10);

        // start held after done, then a fresh request
        wbuf[0] = 16'h00D0; wbuf[1] = 16'h00D1;
        run(1'b1, 8'h30, 4'd1, 3);
        check("hold_w_done_cyc", 32'(done_cyc), 32'd7);
        run(1'b0, 8'h30, 4'd1, 0);
        check("hold_r_vld_cyc", 32'(first_vld), 32'd6);
        check("hold_r_vld_n", 32'(n_vld), 32'd2);
        check("hold_r_d0", 32'(rbuf[0]), 32'h00D0);
        check("hold_r_d1", 32'(rbuf[1]), 32'h00D1);
        check("hold_r_done_cyc", 32'(done_cyc), 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
